// File: rtl/ysyx_25020037_wbu_commit.sv
// Write-back/commit stage: captures one finished instruction, hands the GPR write to
// the register-file stage, then issues the next PC to the IFU and counts retirement.
module ysyx_25020037_wbu_commit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_valid,
  output logic             wbu_ready,
  input  logic [31:0]      lsu_pc,
  input  logic [31:0]      lsu_snpc,
  input  logic [31:0]      lsu_alu_res,
  input  logic [31:0]      lsu_load_data,
  input  logic [31:0]      lsu_csr_rdata,
  input  logic [31:0]      lsu_csr_wdata,
  input  logic [4:0]       lsu_rd,
  input  logic [1:0]       lsu_wb_sel,
  input  logic             lsu_gpr_we,
  input  logic             lsu_ecall,
  input  logic             lsu_mret,
  input  logic             lsu_ebreak,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc,
  output logic             wbu_valid,
  output logic             gpr_we,
  input  logic             gpr_ready,
  output logic [32:0]      wu_to_gu_bus,
  output logic [31:0]      csr_wcsr_data,
  output logic [31:0]      npc,
  output logic             npc_valid,
  input  logic             ifu_ready,
  output logic             halt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {IDLE, WB, REDIR, HALT} state_e;

  state_e             state_q, state_d;
  logic               wbu_ready_q, wbu_ready_d;
  logic               wbu_valid_q, wbu_valid_d;
  logic               npc_valid_q, npc_valid_d;
  logic               halt_q, halt_d;
  logic [31:0]        npc_q, npc_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic [32:0]        bus_q, bus_d;
  logic [31:0]        csr_wdata_q, csr_wdata_d;
  logic [31:0]        snpc_q, snpc_d;
  logic               ecall_q, ecall_d;
  logic               mret_q, mret_d;
  logic               ebreak_q, ebreak_d;

  logic [31:0]        wdata_sel;
  logic [31:0]        redir_pc;

  always_comb begin
    unique case (lsu_wb_sel)
      2'd0:    wdata_sel = lsu_alu_res;
      2'd1:    wdata_sel = lsu_load_data;
      2'd2:    wdata_sel = lsu_csr_rdata;
      default: wdata_sel = lsu_pc + 32'd4;
    endcase
  end

  // mtvec/mepc are read live during REDIR so a CSR update made by this very
  // instruction's write-back is already visible.
  always_comb begin
    if (ecall_q)     redir_pc = mtvec;
    else if (mret_q) redir_pc = mepc;
    else             redir_pc = snpc_q;
  end

  always_comb begin
    state_d      = state_q;
    wbu_ready_d  = wbu_ready_q;
    wbu_valid_d  = wbu_valid_q;
    npc_valid_d  = npc_valid_q;
    halt_d       = halt_q;
    npc_d        = npc_q;
    retire_cnt_d = retire_cnt_q;
    bus_d        = bus_q;
    csr_wdata_d  = csr_wdata_q;
    snpc_d       = snpc_q;
    ecall_d      = ecall_q;
    mret_d       = mret_q;
    ebreak_d     = ebreak_q;
    unique case (state_q)
      IDLE: if (lsu_valid) begin
        bus_d       = {lsu_gpr_we & (lsu_rd != 5'd0), wdata_sel};
        csr_wdata_d = lsu_csr_wdata;
        snpc_d      = lsu_snpc;
        ecall_d     = lsu_ecall;
        mret_d      = lsu_mret;
        ebreak_d    = lsu_ebreak;
        wbu_ready_d = 1'b0;
        wbu_valid_d = 1'b1;
        state_d     = WB;
      end
      WB: if (gpr_ready) begin
        wbu_valid_d = 1'b0;
        npc_valid_d = 1'b1;
        state_d     = REDIR;
      end
      REDIR: if (ifu_ready) begin
        npc_valid_d  = 1'b0;
        npc_d        = redir_pc;
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
        if (ebreak_q) begin
          halt_d  = 1'b1;
          state_d = HALT;
        end else begin
          wbu_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wbu_ready_q  <= 1'b1;
      wbu_valid_q  <= 1'b0;
      npc_valid_q  <= 1'b0;
      halt_q       <= 1'b0;
      npc_q        <= RESET_PC;
      retire_cnt_q <= '0;
      bus_q        <= '0;
      csr_wdata_q  <= '0;
      snpc_q       <= '0;
      ecall_q      <= 1'b0;
      mret_q       <= 1'b0;
      ebreak_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbu_ready_q  <= wbu_ready_d;
      wbu_valid_q  <= wbu_valid_d;
      npc_valid_q  <= npc_valid_d;
      halt_q       <= halt_d;
      npc_q        <= npc_d;
      retire_cnt_q <= retire_cnt_d;
      bus_q        <= bus_d;
      csr_wdata_q  <= csr_wdata_d;
      snpc_q       <= snpc_d;
      ecall_q      <= ecall_d;
      mret_q       <= mret_d;
      ebreak_q     <= ebreak_d;
    end
  end

  assign wbu_ready     = wbu_ready_q;
  assign wbu_valid     = wbu_valid_q;
  assign gpr_we        = wbu_valid_q & bus_q[32];
  assign wu_to_gu_bus  = bus_q;
  assign csr_wcsr_data = csr_wdata_q;
  assign npc           = (state_q == REDIR) ? redir_pc : npc_q;
  assign npc_valid     = npc_valid_q;
  assign halt          = halt_q;
  assign retire_cnt    = retire_cnt_q;

endmodule

// File: tb/tb_ysyx_25020037_wbu_commit.sv
// Directed bench for the commit stage: a vector table run at full speed, plus
// sequences for late CSR update, back-pressure, ebreak halt and mid-flight reset.
module tb_ysyx_25020037_wbu_commit;

  logic        clk, rst;
  logic        lsu_valid, wbu_ready;
  logic [31:0] lsu_pc, lsu_snpc, lsu_alu_res, lsu_load_data, lsu_csr_rdata, lsu_csr_wdata;
  logic [4:0]  lsu_rd;
  logic [1:0]  lsu_wb_sel;
  logic        lsu_gpr_we, lsu_ecall, lsu_mret, lsu_ebreak;
  logic [31:0] mtvec, mepc;
  logic        wbu_valid, gpr_we, gpr_ready;
  logic [32:0] wu_to_gu_bus;
  logic [31:0] csr_wcsr_data, npc;
  logic        npc_valid, ifu_ready, halt;
  logic [63:0] retire_cnt;

  ysyx_25020037_wbu_commit dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
    .lsu_pc(lsu_pc), .lsu_snpc(lsu_snpc), .lsu_alu_res(lsu_alu_res),
    .lsu_load_data(lsu_load_data), .lsu_csr_rdata(lsu_csr_rdata),
    .lsu_csr_wdata(lsu_csr_wdata), .lsu_rd(lsu_rd), .lsu_wb_sel(lsu_wb_sel),
    .lsu_gpr_we(lsu_gpr_we), .lsu_ecall(lsu_ecall), .lsu_mret(lsu_mret),
    .lsu_ebreak(lsu_ebreak), .mtvec(mtvec), .mepc(mepc), .wbu_valid(wbu_valid),
    .gpr_we(gpr_we), .gpr_ready(gpr_ready), .wu_to_gu_bus(wu_to_gu_bus),
    .csr_wcsr_data(csr_wcsr_data), .npc(npc), .npc_valid(npc_valid),
    .ifu_ready(ifu_ready), .halt(halt), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, snpc, alu, ld, crd, cwd;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        we, ec, mr;
    logic [31:0] mtvec, mepc;
    logic [32:0] e_bus;
    logic [31:0] e_npc;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];
  int checks = 0, failures = 0;
  logic [63:0] exp_cnt = 64'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input vec_t v);
    lsu_pc = v.pc; lsu_snpc = v.snpc; lsu_alu_res = v.alu; lsu_load_data = v.ld;
    lsu_csr_rdata = v.crd; lsu_csr_wdata = v.cwd; lsu_rd = v.rd; lsu_wb_sel = v.sel;
    lsu_gpr_we = v.we; lsu_ecall = v.ec; lsu_mret = v.mr; mtvec = v.mtvec; mepc = v.mepc;
  endtask

  // Full-speed flow: capture, WB handshake, REDIR handshake.
  task automatic run_vec(input vec_t v, input string nm, input logic eb);
    drive(v);
    lsu_ebreak = eb;
    lsu_valid  = 1'b1;
    chk({nm, ".ready_in"}, 64'(wbu_ready), 64'd1);
    tick();
    lsu_valid = 1'b0;
    chk({nm, ".wb_valid"}, 64'(wbu_valid), 64'd1);
    chk({nm, ".wb_ready"}, 64'(wbu_ready), 64'd0);
    chk({nm, ".bus"}, 64'(wu_to_gu_bus), 64'(v.e_bus));
    chk({nm, ".gpr_we"}, 64'(gpr_we), 64'(v.e_bus[32]));
    chk({nm, ".csr_wd"}, 64'(csr_wcsr_data), 64'(v.cwd));
    tick();
    chk({nm, ".wb_done"}, 64'(wbu_valid), 64'd0);
    chk({nm, ".npc_valid"}, 64'(npc_valid), 64'd1);
    chk({nm, ".npc"}, 64'(npc), 64'(v.e_npc));
    tick();
    exp_cnt++;
    chk({nm, ".npc_drop"}, 64'(npc_valid), 64'd0);
    chk({nm, ".npc_hold"}, 64'(npc), 64'(v.e_npc));
    chk({nm, ".retire"}, retire_cnt, exp_cnt);
    chk({nm, ".ready_out"}, 64'(wbu_ready), 64'(!eb));
    chk({nm, ".halt"}, 64'(halt), 64'(eb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vt[0] = '{32'h8000_0000, 32'h8000_0004, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 5'd5, 2'd0, 1'b1, 1'b0, 1'b0,
              32'h0, 32'h0, {1'b1, 32'h0000_1234}, 32'h8000_0004};
    vt[1] = '{32'hFFFF_FFFC, 32'h8000_0020, 32'h0000_1111, 32'h0, 32'h0, 32'h0, 5'd0, 2'd3, 1'b1, 1'b0, 1'b0,
              32'h0, 32'h0, {1'b0, 32'h0000_0000}, 32'h8000_0020};
    vt[2] = '{32'h8000_0008, 32'h8000_000C, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd31, 2'd1, 1'b1, 1'b0, 1'b0,
              32'h0, 32'h0, {1'b1, 32'hDEAD_BEEF}, 32'h8000_000C};
    vt[3] = '{32'h8000_000C, 32'h8000_0010, 32'h0000_0009, 32'h7, 32'h0000_000B, 32'h0000_0055, 5'd3, 2'd2, 1'b1, 1'b0, 1'b0,
              32'h0, 32'h0, {1'b1, 32'h0000_000B}, 32'h8000_0010};
    vt[4] = '{32'h8000_0010, 32'h8000_0014, 32'h0000_0077, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0,
              32'h8000_0100, 32'h8000_0010, {1'b0, 32'h0000_0077}, 32'h8000_0100};
    vt[5] = '{32'h8000_0100, 32'h8000_0104, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1,
              32'h8000_0100, 32'h8000_0010, {1'b0, 32'h0}, 32'h8000_0010};
    vt[6] = '{32'h8000_0020, 32'h8000_0024, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1,
              32'h8000_0200, 32'h8000_0300, {1'b0, 32'h0}, 32'h8000_0200};
    vt[7] = '{32'h8000_0040, 32'h8000_0044, 32'h0, 32'h0, 32'h0, 32'h0, 5'd7, 2'd3, 1'b0, 1'b0, 1'b0,
              32'h0, 32'h0, {1'b0, 32'h8000_0044}, 32'h8000_0044};
    vt[8] = '{32'h7FFF_FFFC, 32'h8000_1000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 2'd3, 1'b1, 1'b0, 1'b0,
              32'h0, 32'h0, {1'b1, 32'h8000_0000}, 32'h8000_1000};

    rst = 1'b1; lsu_valid = 1'b0; lsu_ebreak = 1'b0; gpr_ready = 1'b1; ifu_ready = 1'b1;
    drive(vt[0]);
    repeat (2) @(negedge clk);
    chk("rst.ready", 64'(wbu_ready), 64'd1);
    chk("rst.wbu_valid", 64'(wbu_valid), 64'd0);
    chk("rst.npc_valid", 64'(npc_valid), 64'd0);
    chk("rst.npc", 64'(npc), 64'h8000_0000);
    chk("rst.halt", 64'(halt), 64'd0);
    chk("rst.retire", retire_cnt, 64'd0);
    chk("rst.bus", 64'(wu_to_gu_bus), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vt[i], $sformatf("vec%0d", i), 1'b0);

    // CSR written by this instruction's write-back must steer the redirect.
    v = vt[4];
    v.mtvec = 32'h1111_1111;
    drive(v);
    lsu_valid = 1'b1;
    tick();
    lsu_valid = 1'b0;
    tick();
    mtvec = 32'h8000_0100;
    #1;
    chk("late_mtvec.npc", 64'(npc), 64'h8000_0100);
    @(negedge clk);
    tick();
    exp_cnt++;
    mtvec = 32'h0;
    #1;
    chk("late_mtvec.hold", 64'(npc), 64'h8000_0100);
    chk("late_mtvec.retire", retire_cnt, exp_cnt);
    @(negedge clk);

    // Back-pressure on both handshakes.
    v = vt[0];
    v.alu = 32'hA5A5; v.snpc = 32'h8000_0050; v.e_bus = {1'b1, 32'hA5A5};
    drive(v);
    gpr_ready = 1'b0;
    lsu_valid = 1'b1;
    tick();
    lsu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp.wbv%0d", i), 64'(wbu_valid), 64'd1);
      chk($sformatf("bp.bus%0d", i), 64'(wu_to_gu_bus), 64'(v.e_bus));
      tick();
    end
    gpr_ready = 1'b1;
    ifu_ready = 1'b0;
    chk("bp.wbv4", 64'(wbu_valid), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ifu_ready = 1'b1;
      chk($sformatf("bp.npcv%0d", i), 64'(npc_valid), 64'd1);
      chk($sformatf("bp.wbdone%0d", i), 64'(wbu_valid), 64'd0);
      chk($sformatf("bp.noret%0d", i), retire_cnt, exp_cnt);
      tick();
    end
    exp_cnt++;
    chk("bp.npc_drop", 64'(npc_valid), 64'd0);
    chk("bp.npc", 64'(npc), 64'h8000_0050);
    chk("bp.retire", retire_cnt, exp_cnt);

    // ebreak retires, then halts and ignores new work.
    run_vec(vt[2], "ebreak", 1'b1);
    lsu_ebreak = 1'b0;
    lsu_valid = 1'b1;
    repeat (3) tick();
    chk("halt.wbv", 64'(wbu_valid), 64'd0);
    chk("halt.npcv", 64'(npc_valid), 64'd0);
    chk("halt.ready", 64'(wbu_ready), 64'd0);
    chk("halt.sticky", 64'(halt), 64'd1);
    chk("halt.retire", retire_cnt, exp_cnt);
    lsu_valid = 1'b0;

    // Reset while a write is pending in WB.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gpr_ready = 1'b0;
    drive(vt[0]);
    lsu_valid = 1'b1;
    tick();
    lsu_valid = 1'b0;
    chk("mrst.pre_wbv", 64'(wbu_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst.wbv", 64'(wbu_valid), 64'd0);
    chk("mrst.npc", 64'(npc), 64'h8000_0000);
    chk("mrst.retire", retire_cnt, 64'd0);
    chk("mrst.halt", 64'(halt), 64'd0);
    chk("mrst.ready", 64'(wbu_ready), 64'd1);
    chk("mrst.bus", 64'(wu_to_gu_bus), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    gpr_ready = 1'b1;
    repeat (2) tick();
    chk("mrst.no_wbv", 64'(wbu_valid), 64'd0);
    chk("mrst.no_we", 64'(gpr_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
